// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
//
// Parallel-in / serial-out shifter with a valid/ready load handshake.
// A word is accepted when load_valid and load_ready are both high on a
// rising clk edge. It is then sent on ser_out MSB first, one bit per cycle.
// ser_valid/busy mark every bit cycle and ser_last marks bit 0. On the
// ser_last cycle load_ready is raised again, so a new word can follow
// without a gap.
//
// Parameters
//   WIDTH       parallel word width in bits (2..32)
//
// Ports
//   clk         clock, rising-edge active
//   rst         asynchronous active-high reset
//   load_valid  load_data holds a word to send
//   load_ready  block accepts a word this cycle
//   load_data   parallel word, captured only on accept
//   ser_out     serial data bit, MSB first
//   ser_valid   ser_out carries a word bit this cycle
//   ser_last    ser_out carries bit 0 of the word
//   busy        a word is being shifted out (same as ser_valid)
// ---------------------------------------------------------------------------
module piso_serializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    logic               in_shift;
    logic               last_bit;
    logic               accept;

    // Every output is decoded from registered state only, so load_data
    // never has a combinational path to ser_out.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;

        in_shift   = (state_q == SHIFT);
        last_bit   = in_shift && (cnt_q == '0);
        load_ready = !in_shift || last_bit;
        accept     = load_valid && load_ready;

        ser_valid  = in_shift;
        busy       = in_shift;
        ser_last   = last_bit;
        ser_out    = in_shift && shreg_q[WIDTH-1];

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    shreg_d = load_data;
                    cnt_d   = CNT_MAX;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    // Final bit: reload straight away for a gapless stream,
                    // otherwise drop back to IDLE with a cleared register.
                    if (accept) begin
                        shreg_d = load_data;
                        cnt_d   = CNT_MAX;
                    end else begin
                        state_d = IDLE;
                        shreg_d = '0;
                        cnt_d   = '0;
                    end
                end else begin
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    cnt_d   = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                shreg_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// ---------------------------------------------------------------------------
// tb_piso_serializer
//
// Directed bench for piso_serializer at WIDTH=4. A per-cycle vector table
// holds the handshake inputs and the outputs expected during that cycle.
// A companion left-shifting SIPO rebuilds each word from the serial stream.
// Hand-written sequences cover reset in the middle of a word.
// ---------------------------------------------------------------------------
module tb_piso_serializer;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_last;
    logic             busy;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] sipo;

    piso_serializer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .ser_last   (ser_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Downstream SIPO sampling ser_out on the same edges as the DUT.
    always @(posedge clk) begin
        if (ser_valid) sipo <= {sipo[WIDTH-2:0], ser_out};
    end

    typedef struct {
        logic             lv;
        logic [WIDTH-1:0] data;
        logic             rdy;
        logic             vld;
        logic             out;
        logic             last;
        logic             chk_sipo;
        logic [WIDTH-1:0] word;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic lv, input logic [WIDTH-1:0] data,
                       input logic rdy, input logic vld, input logic out,
                       input logic last, input logic chk_sipo,
                       input logic [WIDTH-1:0] word);
        vec_t v;
        v.lv = lv; v.data = data; v.rdy = rdy; v.vld = vld;
        v.out = out; v.last = last; v.chk_sipo = chk_sipo; v.word = word;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic rdy, input logic vld,
                            input logic out, input logic last);
        chk({tag, ".load_ready"}, 32'(load_ready), 32'(rdy));
        chk({tag, ".ser_valid"},  32'(ser_valid),  32'(vld));
        chk({tag, ".busy"},       32'(busy),       32'(vld));
        chk({tag, ".ser_out"},    32'(ser_out),    32'(out));
        chk({tag, ".ser_last"},   32'(ser_last),   32'(last));
    endtask

    // Drive inputs on the falling edge and check the outputs for that cycle.
    task automatic step(input string tag, input logic lv,
                        input logic [WIDTH-1:0] d, input logic rdy,
                        input logic vld, input logic out, input logic last);
        @(negedge clk);
        load_valid = lv;
        load_data  = d;
        chk_outs(tag, rdy, vld, out, last);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        // Single word 1011.
        add(1, 4'b1011, 1, 0, 0, 0, 0, 4'h0);
        add(0, 4'b0000, 0, 1, 1, 0, 0, 4'h0);
        add(0, 4'b0000, 0, 1, 0, 0, 0, 4'h0);
        add(0, 4'b0000, 0, 1, 1, 0, 0, 4'h0);
        add(0, 4'b0000, 1, 1, 1, 1, 0, 4'h0);
        add(0, 4'b0000, 1, 0, 0, 0, 1, 4'b1011);
        // Back-to-back 1100 then 0110 with load_valid held.
        add(1, 4'b1100, 1, 0, 0, 0, 0, 4'h0);
        add(1, 4'b0110, 0, 1, 1, 0, 0, 4'h0);
        add(1, 4'b0110, 0, 1, 1, 0, 0, 4'h0);
        add(1, 4'b0110, 0, 1, 0, 0, 0, 4'h0);
        add(1, 4'b0110, 1, 1, 0, 1, 0, 4'h0);
        add(0, 4'b0000, 0, 1, 0, 0, 1, 4'b1100);
        add(0, 4'b0000, 0, 1, 1, 0, 0, 4'h0);
        add(0, 4'b0000, 0, 1, 1, 0, 0, 4'h0);
        add(0, 4'b0000, 1, 1, 0, 1, 0, 4'h0);
        add(0, 4'b0000, 1, 0, 0, 0, 1, 4'b0110);
        // 0001 in flight while 1111 waits with load_valid high.
        add(1, 4'b0001, 1, 0, 0, 0, 0, 4'h0);
        add(1, 4'b1111, 0, 1, 0, 0, 0, 4'h0);
        add(1, 4'b1111, 0, 1, 0, 0, 0, 4'h0);
        add(1, 4'b1111, 0, 1, 0, 0, 0, 4'h0);
        add(1, 4'b1111, 1, 1, 1, 1, 0, 4'h0);
        add(0, 4'b0000, 0, 1, 1, 0, 1, 4'b0001);
        add(0, 4'b0000, 0, 1, 1, 0, 0, 4'h0);
        add(0, 4'b0000, 0, 1, 1, 0, 0, 4'h0);
        add(0, 4'b0000, 1, 1, 1, 1, 0, 4'h0);
        add(0, 4'b0000, 1, 0, 0, 0, 1, 4'b1111);
        // 1001 with load_data toggling underneath.
        add(1, 4'b1001, 1, 0, 0, 0, 0, 4'h0);
        add(0, 4'b0110, 0, 1, 1, 0, 0, 4'h0);
        add(0, 4'b1001, 0, 1, 0, 0, 0, 4'h0);
        add(0, 4'b1111, 0, 1, 0, 0, 0, 4'h0);
        add(0, 4'b0000, 1, 1, 1, 1, 0, 4'h0);
        add(0, 4'b0110, 1, 0, 0, 0, 1, 4'b1001);

        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        sipo       = '0;
        #1;
        chk_outs("reset", 1, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) step("idle", 0, 4'b0000, 1, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i].lv, vecs[i].data,
                 vecs[i].rdy, vecs[i].vld, vecs[i].out, vecs[i].last);
            if (vecs[i].chk_sipo)
                chk($sformatf("vec%0d.sipo", i), 32'(sipo), 32'(vecs[i].word));
        end

        // Reset asserted mid-cycle during 1010, after its second bit.
        step("abort.load", 1, 4'b1010, 1, 0, 0, 0);
        step("abort.b3",   0, 4'b0000, 0, 1, 1, 0);
        step("abort.b2",   0, 4'b0000, 0, 1, 0, 0);
        @(posedge clk);
        #2;
        chk("abort.b1.ser_out", 32'(ser_out), 32'(1));
        rst        = 1'b1;
        load_valid = 1'b1;
        load_data  = 4'b1111;
        #1;
        chk_outs("abort.async", 1, 0, 0, 0);
        @(negedge clk);
        chk_outs("abort.held", 1, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        chk_outs("abort.held2", 1, 0, 0, 0);
        // Release with the next word already offered: first edge accepts.
        rst        = 1'b0;
        load_valid = 1'b1;
        load_data  = 4'b0101;
        step("after.b3", 0, 4'b0000, 0, 1, 0, 0);
        step("after.b2", 0, 4'b0000, 0, 1, 1, 0);
        step("after.b1", 0, 4'b0000, 0, 1, 0, 0);
        step("after.b0", 0, 4'b0000, 1, 1, 1, 1);
        step("after.idle", 0, 4'b0000, 1, 0, 0, 0);
        chk("after.sipo", 32'(sipo), 32'(4'b0101));
        step("after.idle2", 0, 4'b0000, 1, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
